// File: rtl/regfile_port_arbiter.sv
// Two-requester arbiter for the register bank's write port (we3/a3/wd3) and read port (a1/rd1).
// Round-robin by default; define REGARB_FIXED_PRIO_EN for fixed priority to requester 0.
module regfile_port_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  wreq,
    input  logic [3:0]  waddr0,
    input  logic [3:0]  waddr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  wgnt,
    output logic [1:0]  werr,
    input  logic [1:0]  rreq,
    input  logic [3:0]  raddr0,
    input  logic [3:0]  raddr1,
    output logic [1:0]  rgnt,
    output logic [1:0]  rvalid,
    output logic [31:0] rdata,
    output logic        we3,
    output logic [3:0]  a3,
    output logic [31:0] wd3,
    output logic [3:0]  a1,
    input  logic [31:0] rd1
);
    typedef enum logic {W_IDLE, W_ISSUE} wstate_t;
    typedef enum logic {R_IDLE, R_ISSUE} rstate_t;

    wstate_t     wstate;
    rstate_t     rstate;
    logic [1:0]  weligible;
    logic [1:0]  religible;
    logic        wwin;
    logic        rwin;
    logic [3:0]  wsel_addr;
    logic [31:0] wsel_data;
    logic [3:0]  rsel_addr;

    // The requester holding the grant this cycle sits out the next decision.
    assign weligible = wreq & ~((wstate == W_ISSUE) ? wgnt : 2'b00);
    assign religible = rreq & ~((rstate == R_ISSUE) ? rgnt : 2'b00);

`ifdef REGARB_FIXED_PRIO_EN
    assign wwin = ~weligible[0];
    assign rwin = ~religible[0];
`else
    logic wptr;
    logic rptr;

    assign wwin = (weligible == 2'b11) ? wptr : weligible[1];
    assign rwin = (religible == 2'b11) ? rptr : religible[1];

    // Pointer names the requester favoured on the next tie; it flips to the loser after a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
        end else begin
            if (weligible != 2'b00) wptr <= ~wwin;
            if (religible != 2'b00) rptr <= ~rwin;
        end
    end
`endif

    assign wsel_addr = wwin ? waddr1 : waddr0;
    assign wsel_data = wwin ? wdata1 : wdata0;
    assign rsel_addr = rwin ? raddr1 : raddr0;
    assign rdata     = rd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate <= W_IDLE;
            wgnt   <= 2'b00;
            werr   <= 2'b00;
            we3    <= 1'b1;
            a3     <= 4'd0;
            wd3    <= 32'd0;
        end else begin
            wgnt <= 2'b00;
            werr <= 2'b00;
            we3  <= 1'b1;
            if (weligible != 2'b00) begin
                wstate <= W_ISSUE;
                wgnt   <= wwin ? 2'b10 : 2'b01;
                a3     <= wsel_addr;
                wd3    <= wsel_data;
                // R15 belongs to another path: grant the request but keep the bank untouched.
                if (wsel_addr == 4'd15) begin
                    werr <= wwin ? 2'b10 : 2'b01;
                end else begin
                    we3 <= 1'b0;
                end
            end else begin
                wstate <= W_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate <= R_IDLE;
            rgnt   <= 2'b00;
            rvalid <= 2'b00;
            a1     <= 4'd0;
        end else begin
            rgnt   <= 2'b00;
            rvalid <= rgnt;
            if (religible != 2'b00) begin
                rstate <= R_ISSUE;
                rgnt   <= rwin ? 2'b10 : 2'b01;
                a1     <= rsel_addr;
            end else begin
                rstate <= R_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Testbench for regfile_port_arbiter: directed cases then random traffic against a reference model,
// with a behavioural register bank (falling-edge write, rising-edge read).
module tb_regfile_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wreq = 2'b00;
    logic [1:0]  rreq = 2'b00;
    logic [3:0]  waddr0 = 4'd0, waddr1 = 4'd0, raddr0 = 4'd0, raddr1 = 4'd0;
    logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;
    logic [31:0] rd1;
    logic [1:0]  wgnt, werr, rgnt, rvalid;
    logic [31:0] rdata, wd3;
    logic        we3;
    logic [3:0]  a3, a1;

    logic [31:0] bank [16];
    logic        bank_init = 1'b1;

`ifdef REGARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .wreq(wreq), .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
        .wgnt(wgnt), .werr(werr),
        .rreq(rreq), .raddr0(raddr0), .raddr1(raddr1),
        .rgnt(rgnt), .rvalid(rvalid), .rdata(rdata),
        .we3(we3), .a3(a3), .wd3(wd3), .a1(a1), .rd1(rd1)
    );

    function automatic logic [31:0] init_val(int i);
        return (i == 15) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i);
    endfunction

    always @(negedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < 16; i++) bank[i] <= init_val(i);
        end else if (we3 === 1'b0) begin
            bank[a3] <= wd3;
        end
    end

    always @(posedge clk) rd1 <= bank[a1];

    // Reference model state: what is being issued in the current cycle, and who was last served.
    logic [31:0] shadow [16];
    logic [1:0]  cw_gnt, cr_gnt;
    logic        cw_err;
    logic [3:0]  cw_addr, cr_addr;
    logic [31:0] cw_data;
    bit          w_last, r_last;
    int          total = 0;
    int          bad = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cw_gnt = 2'b00; cr_gnt = 2'b00; cw_err = 1'b0;
        cw_addr = 4'd0; cr_addr = 4'd0; cw_data = 32'd0;
        w_last = 1'b1; r_last = 1'b1;
    endtask

    // Eligible = requesting and not served this cycle; a tie goes to whoever was not served last.
    function automatic int pick(logic [1:0] elig, bit last);
        if (elig == 2'b01) return 0;
        if (elig == 2'b10) return 1;
        if (elig == 2'b11) return (FIXED || last) ? 0 : 1;
        return -1;
    endfunction

    task automatic step(output logic [1:0] gw, output logic [1:0] gr);
        int          wk, rk;
        logic [3:0]  wa, ra;
        logic [31:0] wd, exp_rd;
        logic [1:0]  exp_rv;
        logic        wbad;
        if (cw_gnt != 2'b00 && !cw_err) shadow[cw_addr] = cw_data;
        exp_rv = cr_gnt;
        exp_rd = shadow[cr_addr];
        wk = pick(wreq & ~cw_gnt, w_last);
        rk = pick(rreq & ~cr_gnt, r_last);
        wa = (wk == 1) ? waddr1 : waddr0;
        wd = (wk == 1) ? wdata1 : wdata0;
        ra = (rk == 1) ? raddr1 : raddr0;
        gw = (wk == 0) ? 2'b01 : (wk == 1) ? 2'b10 : 2'b00;
        gr = (rk == 0) ? 2'b01 : (rk == 1) ? 2'b10 : 2'b00;
        wbad = (wk >= 0) && (wa == 4'd15);
        @(posedge clk);
        #1;
        chk("wgnt", wgnt, gw);
        chk("werr", werr, wbad ? gw : 2'b00);
        chk("we3", we3, !((wk >= 0) && !wbad));
        if (wk >= 0 && !wbad) begin
            chk("a3", a3, wa);
            chk("wd3", wd3, wd);
        end
        chk("rgnt", rgnt, gr);
        if (rk >= 0) chk("a1", a1, ra);
        chk("rvalid", rvalid, exp_rv);
        if (exp_rv != 2'b00) chk("rdata", rdata, exp_rd);
        cw_gnt = gw; cw_err = wbad; cw_addr = wa; cw_data = wd;
        cr_gnt = gr; cr_addr = ra;
        if (wk >= 0) w_last = wk[0];
        if (rk >= 0) r_last = rk[0];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wreq = 2'b00; rreq = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] gw, gr;
        logic [1:0] seq [4];
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
        for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
        model_reset();
        gw = 2'b00; gr = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bank_init = 1'b0;
        rst_n = 1'b1;

        chk("rst_we3", we3, 1'b1);
        chk("rst_a3", a3, 4'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_a1", a1, 4'd0);
        chk("rst_wgnt", wgnt, 2'b00);
        chk("rst_werr", werr, 2'b00);
        chk("rst_rgnt", rgnt, 2'b00);
        chk("rst_rvalid", rvalid, 2'b00);

        // Single write to R3 then a read back.
        wreq = 2'b01; waddr0 = 4'd3; wdata0 = 32'h12345678;
        step(gw, gr);
        chk("w3_we3", we3, 1'b0);
        chk("w3_wd3", wd3, 32'h12345678);
        wreq = 2'b00;
        step(gw, gr);
        rreq = 2'b01; raddr0 = 4'd3;
        step(gw, gr);
        rreq = 2'b00;
        step(gw, gr);
        chk("r3_rvalid", rvalid, 2'b01);
        chk("r3_rdata", rdata, 32'h12345678);

        // Reset asserted in the middle of a write issue cycle.
        wreq = 2'b01; waddr0 = 4'd7; wdata0 = 32'hCAFE0007;
        step(gw, gr);
        rst_n = 1'b0;
        #1;
        chk("midrst_we3", we3, 1'b1);
        chk("midrst_wgnt", wgnt, 2'b00);
        chk("midrst_werr", werr, 2'b00);
        chk("midrst_rgnt", rgnt, 2'b00);
        model_reset();
        wreq = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Both writers held: grants alternate starting with requester 0.
        wreq = 2'b11; waddr0 = 4'd4; waddr1 = 4'd6; wdata0 = 32'h4000_0000; wdata1 = 32'h6000_0000;
        for (int n = 0; n < 4; n++) begin
            step(gw, gr);
            chk("alt_seq", wgnt, seq[n]);
            if (gw[0]) wdata0 = wdata0 + 32'd1;
            if (gw[1]) wdata1 = wdata1 + 32'd1;
        end
        wreq = 2'b00;
        step(gw, gr);
        step(gw, gr);

        do_reset();

        // Write to R15 is granted with an error and never reaches the bank.
        wreq = 2'b10; waddr1 = 4'd15; wdata1 = 32'h5555AAAA;
        step(gw, gr);
        chk("r15_wgnt", wgnt, 2'b10);
        chk("r15_werr", werr, 2'b10);
        chk("r15_we3", we3, 1'b1);
        wreq = 2'b00;
        step(gw, gr);

        // Two reads alongside a write of 0xA5 to R5.
        rreq = 2'b11; raddr0 = 4'd2; raddr1 = 4'd5;
        wreq = 2'b01; waddr0 = 4'd5; wdata0 = 32'h0000_00A5;
        step(gw, gr);
        chk("rd_gnt0", rgnt, 2'b01);
        rreq = 2'b10; wreq = 2'b00;
        step(gw, gr);
        chk("rd_gnt1", rgnt, 2'b10);
        chk("rd_rv0", rvalid, 2'b01);
        chk("rd_r2", rdata, 32'h1000_0002);
        rreq = 2'b00;
        step(gw, gr);
        chk("rd_rv1", rvalid, 2'b10);
        chk("rd_r5", rdata, 32'h0000_00A5);

        // Random traffic obeying the hold-until-grant rule, with occasional abandoned requests.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (wreq[k] && gw[k]) begin
                    if ($urandom_range(1) == 0) wreq[k] = 1'b0;
                    else if (k == 0) begin waddr0 = 4'($urandom_range(15)); wdata0 = $urandom; end
                    else begin waddr1 = 4'($urandom_range(15)); wdata1 = $urandom; end
                end else if (wreq[k]) begin
                    if ($urandom_range(19) == 0) wreq[k] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    wreq[k] = 1'b1;
                    if (k == 0) begin waddr0 = 4'($urandom_range(15)); wdata0 = $urandom; end
                    else begin waddr1 = 4'($urandom_range(15)); wdata1 = $urandom; end
                end
                if (rreq[k] && gr[k]) begin
                    if ($urandom_range(1) == 0) rreq[k] = 1'b0;
                    else if (k == 0) raddr0 = 4'($urandom_range(15));
                    else raddr1 = 4'($urandom_range(15));
                end else if (rreq[k]) begin
                    if ($urandom_range(19) == 0) rreq[k] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    rreq[k] = 1'b1;
                    if (k == 0) raddr0 = 4'($urandom_range(15));
                    else raddr1 = 4'($urandom_range(15));
                end
            end
            step(gw, gr);
        end
        wreq = 2'b00; rreq = 2'b00;
        step(gw, gr);
        step(gw, gr);

        chk("bank_r15", bank[15], 32'hDEADBEEF);
        for (int i = 0; i < 16; i++) chk("bank_contents", bank[i], shadow[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
